jtdd_vtimer: RTL and testbench
==============================

JTDD_VTIMER -- requirements
Module: jtdd_vtimer

Interface
REQ-001 SHALL have parameters (name, default, meaning), one per line:
 HW 9 H counter width; VW 9 V counter width
 HTOTAL 384 pixels per line; VTOTAL 272 lines per frame
 HBSTART 256 first H with HBL high, held high to HTOTAL-1
 HSSTART 304, HSEND 336 HS high for HSSTART <= H < HSEND
 VBSTART 240, VBEND 8 VBL high for V >= VBSTART or V < VBEND
 VSSTART 248, VSEND 256 VS high for VSSTART <= V < VSEND
 DLY 2 blanking delay depth in pxl_cen steps, range 1..8
REQ-002 SHALL have ports (name direction width meaning), one per line:
 clk in 1 system clock, single clock domain
 rst_n in 1 reset, asynchronous, active-low
 pxl_cen in 1 pixel clock enable
 flip in 1 screen flip request
 ims_line in VW mid-screen interrupt line number
 HCNT out HW raw H count; VCNT out VW raw V count
 HPOS out HW H position, flip applied; VPOS out VW V position, flip applied
 HBL out 1 H blank; VBL out 1 V blank; HS out 1 H sync; VS out 1 V sync
 LHBL_dly out 1 ~HBL delayed DLY steps; LVBL_dly out 1 ~VBL delayed DLY steps
 IMS out 1 interrupt middle screen; frame out 1 start-of-frame strobe; H8 out 1 HPOS[3]

Function
REQ-003 SHALL change all state only on clk rising edges with pxl_cen=1, except async reset.
REQ-004 SHALL increment HCNT each pxl_cen, wrapping HTOTAL-1 -> 0.
REQ-005 SHALL increment VCNT on HCNT wrap only, wrapping VTOTAL-1 -> 0; VCNT constant within a line.
REQ-006 SHALL register HBL, HS, VBL, VS from the next count value, so they align with HCNT/VCNT in the same cycle (zero latency vs counters).
REQ-007 SHALL sample flip into internal flip_l only when HCNT and VCNT both wrap to 0 (frame boundary); mid-frame flip changes have no effect until next frame.
REQ-008 SHALL output HPOS = HCNT XOR {HW{flip_l}}, VPOS = VCNT XOR {VW{flip_l}}; H8 = HPOS[3].
REQ-009 SHALL implement LHBL_dly/LVBL_dly as DLY-stage shift registers of ~HBL/~VBL advanced on pxl_cen.
REQ-010 SHALL drive IMS high for the entire line where VCNT == ims_line, low otherwise; ims_line >= VTOTAL gives IMS permanently low; ims_line sampled at HCNT wrap.
REQ-011 SHALL pulse frame high for exactly one pxl_cen step, the step where HCNT=0 and VCNT=0.
REQ-012 SHALL stop counting, holding all outputs, while pxl_cen=0 indefinitely.
REQ-013 SHALL fail elaboration/simulation ($error) if HTOTAL > 2**HW, VTOTAL > 2**VW, DLY outside 1..8, HBSTART >= HTOTAL, or VBSTART >= VTOTAL.
REQ-014 SHALL support HSEND <= HSSTART / VSEND <= VSSTART as sync never asserted (no wrap-around sync window).

Reset
REQ-015 SHALL on rst_n low: HCNT=0, VCNT=0, flip_l=0, HBL=0, HS=0, VS=0, VBL=1 (when VBEND>0), IMS=0 unless ims_line==0, frame=0, LHBL_dly=0, LVBL_dly=0, all delay stages 0.
REQ-016 SHALL on rst_n release mid-line restart at HCNT=0/VCNT=0 on first pxl_cen; first frame pulse occurs after one full frame (VTOTAL*HTOTAL steps).

Verification
REQ-017 Defaults, pxl_cen every 4th clk, 2 frames -> HCNT period 384, VCNT period 272, frame pulses 104448 pxl_cen apart.
REQ-018 Defaults, line 100 -> HBL high H 256..383, HS high H 304..335, LHBL_dly falls 2 pxl_cen after HBL rises.
REQ-019 Defaults -> VBL high for V 240..271 and 0..7, VS high V 248..255, LVBL_dly lags VBL by 2 pxl_cen.
REQ-020 flip 0->1 at V=120 -> HPOS/VPOS unchanged until frame boundary, then HPOS=~HCNT (H=0 gives 511), VPOS=~VCNT.
REQ-021 ims_line=16 -> IMS high exactly 384 pxl_cen during V=16; ims_line=300 -> IMS never high.
REQ-022 rst_n low for 3 clk at H=200,V=50 -> all outputs at REQ-015 values immediately, counting restarts from 0/0; HW=8, HTOTAL=384 -> $error.

Source files
------------

// File: rtl/jtdd_vtimer.sv
// Video timing generator: H/V counters, blanking and sync, flip-aware positions,
// delayed blanking, mid-screen interrupt line and start-of-frame strobe.
module jtdd_vtimer #(
  parameter int HW      = 9,
  parameter int VW      = 9,
  parameter int HTOTAL  = 384,
  parameter int VTOTAL  = 272,
  parameter int HBSTART = 256,
  parameter int HSSTART = 304,
  parameter int HSEND   = 336,
  parameter int VBSTART = 240,
  parameter int VBEND   = 8,
  parameter int VSSTART = 248,
  parameter int VSEND   = 256,
  parameter int DLY     = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          pxl_cen,
  input  logic          flip,
  input  logic [VW-1:0] ims_line,
  output logic [HW-1:0] HCNT,
  output logic [VW-1:0] VCNT,
  output logic [HW-1:0] HPOS,
  output logic [VW-1:0] VPOS,
  output logic          HBL,
  output logic          VBL,
  output logic          HS,
  output logic          VS,
  output logic          LHBL_dly,
  output logic          LVBL_dly,
  output logic          IMS,
  output logic          frame,
  output logic          H8
);

  localparam logic [HW-1:0] H_LAST  = HW'(HTOTAL - 1);
  localparam logic [VW-1:0] V_LAST  = VW'(VTOTAL - 1);
  localparam logic          VBL_RST = (VBEND > 0) ? 1'b1 : 1'b0;

  if (HTOTAL > 2**HW) begin : g_err_htotal
    $error("jtdd_vtimer: HTOTAL does not fit in HW bits");
  end
  if (VTOTAL > 2**VW) begin : g_err_vtotal
    $error("jtdd_vtimer: VTOTAL does not fit in VW bits");
  end
  if (DLY < 1 || DLY > 8) begin : g_err_dly
    $error("jtdd_vtimer: DLY must be in 1..8");
  end
  if (HBSTART >= HTOTAL) begin : g_err_hbstart
    $error("jtdd_vtimer: HBSTART must be below HTOTAL");
  end
  if (VBSTART >= VTOTAL) begin : g_err_vbstart
    $error("jtdd_vtimer: VBSTART must be below VTOTAL");
  end

  logic [HW-1:0]  hcnt_r, h_next_s, hpos_r;
  logic [VW-1:0]  vcnt_r, v_next_s, vpos_r;
  logic           h_wrap_s, frame_next_s, flip_next_s;
  logic           hbl_next_s, hs_next_s, vbl_next_s, vs_next_s;
  logic           flip_r, hbl_r, hs_r, vbl_r, vs_r, frame_r;
  logic           ims_r, ims_valid_r;
  logic [DLY-1:0] lhbl_sr_r, lvbl_sr_r;

  // Next count values; all decoded outputs are registered from these so they line up with the counters
  always_comb begin
    h_wrap_s = (hcnt_r == H_LAST);
    h_next_s = hcnt_r + HW'(1);
    v_next_s = vcnt_r;
    if (h_wrap_s) begin
      h_next_s = {HW{1'b0}};
      v_next_s = (vcnt_r == V_LAST) ? {VW{1'b0}} : vcnt_r + VW'(1);
    end else begin
      v_next_s = vcnt_r;
    end
    frame_next_s = h_wrap_s && (v_next_s == {VW{1'b0}});
    flip_next_s  = frame_next_s ? flip : flip_r;
    hbl_next_s   = int'(h_next_s) >= HBSTART;
    hs_next_s    = (int'(h_next_s) >= HSSTART) && (int'(h_next_s) < HSEND);
    vbl_next_s   = (int'(v_next_s) >= VBSTART) || (int'(v_next_s) < VBEND);
    vs_next_s    = (int'(v_next_s) >= VSSTART) && (int'(v_next_s) < VSEND);
  end

  // Timing state, advanced only on pixel clock enable
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hcnt_r      <= {HW{1'b0}};
      vcnt_r      <= {VW{1'b0}};
      hpos_r      <= {HW{1'b0}};
      vpos_r      <= {VW{1'b0}};
      flip_r      <= 1'b0;
      hbl_r       <= 1'b0;
      hs_r        <= 1'b0;
      vbl_r       <= VBL_RST;
      vs_r        <= 1'b0;
      frame_r     <= 1'b0;
      ims_r       <= 1'b0;
      ims_valid_r <= 1'b0;
      lhbl_sr_r   <= {DLY{1'b0}};
      lvbl_sr_r   <= {DLY{1'b0}};
    end else if (pxl_cen) begin
      hcnt_r  <= h_next_s;
      vcnt_r  <= v_next_s;
      flip_r  <= flip_next_s;
      hpos_r  <= h_next_s ^ {HW{flip_next_s}};
      vpos_r  <= v_next_s ^ {VW{flip_next_s}};
      hbl_r   <= hbl_next_s;
      hs_r    <= hs_next_s;
      vbl_r   <= vbl_next_s;
      vs_r    <= vs_next_s;
      frame_r <= frame_next_s;
      // Delay lines take the current (pre-update) blanking so the lag is exactly DLY steps
      lhbl_sr_r[0] <= ~hbl_r;
      lvbl_sr_r[0] <= ~vbl_r;
      for (int i = 1; i < DLY; i++) begin
        lhbl_sr_r[i] <= lhbl_sr_r[i-1];
        lvbl_sr_r[i] <= lvbl_sr_r[i-1];
      end
      if (h_wrap_s) begin
        ims_valid_r <= 1'b1;
        ims_r       <= (v_next_s == ims_line);
      end
    end
  end

  assign HCNT     = hcnt_r;
  assign VCNT     = vcnt_r;
  assign HPOS     = hpos_r;
  assign VPOS     = vpos_r;
  assign H8       = hpos_r[3];
  assign HBL      = hbl_r;
  assign HS       = hs_r;
  assign VBL      = vbl_r;
  assign VS       = vs_r;
  assign frame    = frame_r;
  assign LHBL_dly = lhbl_sr_r[DLY-1];
  assign LVBL_dly = lvbl_sr_r[DLY-1];
  // Until the first line wrap after reset no sample exists, so line 0 compares live
  assign IMS      = ims_valid_r ? ims_r : (vcnt_r == ims_line);

endmodule

// File: tb/tb_jtdd_vtimer.sv
// Directed bench for jtdd_vtimer on a scaled-down raster (48x20) so whole
// frames fit in a short run; pxl_cen fires every 4th clock.
module tb_jtdd_vtimer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       pxl_cen = 1'b0;
  logic       flip = 1'b0;
  logic [8:0] ims_line = 9'd5;
  logic [8:0] HCNT, VCNT, HPOS, VPOS;
  logic       HBL, VBL, HS, VS, LHBL_dly, LVBL_dly, IMS, frame, H8;

  int n_checks = 0;
  int n_fail   = 0;
  int n        = 0;

  jtdd_vtimer #(
    .HW(9), .VW(9), .HTOTAL(48), .VTOTAL(20),
    .HBSTART(32), .HSSTART(38), .HSEND(42),
    .VBSTART(16), .VBEND(2), .VSSTART(17), .VSEND(19), .DLY(2)
  ) dut (
    .clk(clk), .rst_n(rst_n), .pxl_cen(pxl_cen), .flip(flip), .ims_line(ims_line),
    .HCNT(HCNT), .VCNT(VCNT), .HPOS(HPOS), .VPOS(VPOS),
    .HBL(HBL), .VBL(VBL), .HS(HS), .VS(VS),
    .LHBL_dly(LHBL_dly), .LVBL_dly(LVBL_dly), .IMS(IMS), .frame(frame), .H8(H8)
  );

  always #5 clk = ~clk;

  typedef struct {
    int       step;
    logic     flip;
    int       h, v, hpos, vpos;
    logic     hbl, hs, vbl, vs, lhbl, lvbl, ims, frame;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input int step, input logic fl, input int h, input int v,
                     input int hp, input int vp, input logic hbl, input logic hs,
                     input logic vbl, input logic vs, input logic lh, input logic lv,
                     input logic ims, input logic fr);
    vec_t r;
    r.step = step; r.flip = fl; r.h = h; r.v = v; r.hpos = hp; r.vpos = vp;
    r.hbl = hbl; r.hs = hs; r.vbl = vbl; r.vs = vs; r.lhbl = lh; r.lvbl = lv;
    r.ims = ims; r.frame = fr;
    tbl.push_back(r);
  endtask

  function automatic logic [44:0] pack_exp(input vec_t r);
    logic [8:0] hp;
    hp = 9'(r.hpos);
    return {9'(r.h), 9'(r.v), hp, 9'(r.vpos), hp[3], r.hbl, r.hs, r.vbl, r.vs,
            r.lhbl, r.lvbl, r.ims, r.frame};
  endfunction

  function automatic logic [44:0] pack_act();
    return {HCNT, VCNT, HPOS, VPOS, H8, HBL, HS, VBL, VS, LHBL_dly, LVBL_dly, IMS, frame};
  endfunction

  task automatic check_vec(input string name, input logic [44:0] got, input logic [44:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got h=%0d v=%0d hpos=%0d vpos=%0d flags(h8,hbl,hs,vbl,vs,lhbl,lvbl,ims,frame)=%b, want h=%0d v=%0d hpos=%0d vpos=%0d flags=%b",
               name, got[44:36], got[35:27], got[26:18], got[17:9], got[8:0],
               exp[44:36], exp[35:27], exp[26:18], exp[17:9], exp[8:0]);
    end
  endtask

  task automatic check_int(input string name, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, want %0d", name, got, exp);
    end
  endtask

  // One pixel step: enable high for exactly one rising edge, then idle to 4 clocks
  task automatic tick();
    @(negedge clk) pxl_cen = 1'b1;
    @(negedge clk) pxl_cen = 1'b0;
    @(negedge clk);
    @(negedge clk);
    n++;
  endtask

  initial begin
    int ticks, ims_cnt, target;
    logic [44:0] rst_vec, step1_vec;

    //  step flip  h  v hpos vpos hbl hs vbl vs lhbl lvbl ims frame
    add(  0, 0,    0, 0,   0,  0, 0, 0, 1, 0, 0, 0, 0, 0);
    add(  1, 0,    1, 0,   1,  0, 0, 0, 1, 0, 0, 0, 0, 0);
    add(  2, 0,    2, 0,   2,  0, 0, 0, 1, 0, 1, 0, 0, 0);
    add( 32, 0,   32, 0,  32,  0, 1, 0, 1, 0, 1, 0, 0, 0);
    add( 34, 0,   34, 0,  34,  0, 1, 0, 1, 0, 0, 0, 0, 0);
    add( 38, 0,   38, 0,  38,  0, 1, 1, 1, 0, 0, 0, 0, 0);
    add( 41, 0,   41, 0,  41,  0, 1, 1, 1, 0, 0, 0, 0, 0);
    add( 42, 0,   42, 0,  42,  0, 1, 0, 1, 0, 0, 0, 0, 0);
    add( 48, 0,    0, 1,   0,  1, 0, 0, 1, 0, 0, 0, 0, 0);
    add( 50, 0,    2, 1,   2,  1, 0, 0, 1, 0, 1, 0, 0, 0);
    add( 96, 0,    0, 2,   0,  2, 0, 0, 0, 0, 0, 0, 0, 0);
    add( 98, 0,    2, 2,   2,  2, 0, 0, 0, 0, 1, 1, 0, 0);
    add(239, 0,   47, 4,  47,  4, 1, 0, 0, 0, 0, 1, 0, 0);
    add(240, 0,    0, 5,   0,  5, 0, 0, 0, 0, 0, 1, 1, 0);
    add(287, 0,   47, 5,  47,  5, 1, 0, 0, 0, 0, 1, 1, 0);
    add(288, 0,    0, 6,   0,  6, 0, 0, 0, 0, 0, 1, 0, 0);
    add(300, 1,   12, 6,  12,  6, 0, 0, 0, 0, 1, 1, 0, 0);
    add(768, 1,    0,16,   0, 16, 0, 0, 1, 0, 0, 1, 0, 0);
    add(770, 1,    2,16,   2, 16, 0, 0, 1, 0, 1, 0, 0, 0);
    add(816, 1,    0,17,   0, 17, 0, 0, 1, 1, 0, 0, 0, 0);
    add(912, 1,    0,19,   0, 19, 0, 0, 1, 0, 0, 0, 0, 0);
    add(959, 1,   47,19,  47, 19, 1, 0, 1, 0, 0, 0, 0, 0);
    add(960, 1,    0, 0, 511,511, 0, 0, 1, 0, 0, 0, 0, 1);
    add(961, 1,    1, 0, 510,511, 0, 0, 1, 0, 0, 0, 0, 0);
    add(962, 1,    2, 0, 509,511, 0, 0, 1, 0, 1, 0, 0, 0);

    rst_vec   = pack_exp(tbl[0]);
    step1_vec = pack_exp(tbl[1]);

    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    foreach (tbl[i]) begin
      flip = tbl[i].flip;
      while (n < tbl[i].step) tick();
      check_vec($sformatf("vec_step%0d", tbl[i].step), pack_act(), pack_exp(tbl[i]));
    end

    // Next frame: pulse spacing from step 962, and IMS on line 16 only
    ims_line = 9'd16;
    ticks = 0; ims_cnt = 0;
    while (ticks < 2000) begin
      tick(); ticks++;
      if (frame) break;
      if (IMS) ims_cnt++;
    end
    check_int("frame_gap_first", ticks, 958);
    check_int("ims_line16_count", ims_cnt, 48);

    // Full frame with an out-of-range interrupt line
    ims_line = 9'd300;
    ticks = 0; ims_cnt = 0;
    while (ticks < 2000) begin
      tick(); ticks++;
      if (IMS) ims_cnt++;
      if (frame) break;
    end
    check_int("frame_period", ticks, 960);
    check_int("ims_line300_count", ims_cnt, 0);

    // Enable held low: frame strobe and counters freeze
    repeat (40) @(negedge clk);
    check_vec("hold_no_cen", {HCNT, VCNT, 26'd0, frame}, {9'd0, 9'd0, 26'd0, 1'b1});
    tick();
    check_int("frame_one_step", int'(frame), 0);

    // Async reset mid-line at H=20, V=7
    target = 7 * 48 + 20;
    while ((n % 960) != target && n < 10000) tick();
    check_int("pre_reset_hcnt", int'(HCNT), 20);
    @(negedge clk) rst_n = 1'b0;
    #2;
    check_vec("async_reset", pack_act(), rst_vec);
    repeat (3) @(negedge clk);
    check_vec("reset_held", pack_act(), rst_vec);
    rst_n = 1'b1;
    n = 0;
    repeat (2) @(negedge clk);
    check_vec("post_reset_idle", pack_act(), rst_vec);
    tick();
    check_vec("post_reset_step1", pack_act(), step1_vec);
    ticks = 1;
    while (ticks < 2000 && !frame) begin
      tick(); ticks++;
    end
    check_int("first_frame_after_reset", ticks, 960);
    check_vec("flip_after_reset_frame", {HCNT, VCNT, HPOS, VPOS, 9'd0},
              {9'd0, 9'd0, 9'd511, 9'd511, 9'd0});

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
